// File: rtl/bp_fe_queue_issuer.sv
// FE->BE fetch queue transmitter: packs fetch results into fe_queue messages,
// buffers them in a small FIFO and stalls fetch after an exception until a redirect.
module bp_fe_queue_issuer #(
  parameter int unsigned vaddr_width_p = 39,
  parameter int unsigned instr_width_p = 32,
  parameter int unsigned meta_width_p  = 36,
  parameter int unsigned els_p         = 2
) (
  input  logic                                                 clk_i,
  input  logic                                                 reset_n_i,
  input  logic                                                 fetch_v_i,
  output logic                                                 fetch_ready_o,
  input  logic [vaddr_width_p-1:0]                             fetch_pc_i,
  input  logic [instr_width_p-1:0]                             fetch_instr_i,
  input  logic [meta_width_p-1:0]                              fetch_meta_i,
  input  logic                                                 fetch_exc_v_i,
  input  logic [1:0]                                           fetch_exc_i,
  input  logic                                                 flush_i,
  output logic [vaddr_width_p+instr_width_p+meta_width_p:0]    fe_queue_o,
  output logic                                                 fe_queue_v_o,
  input  logic                                                 fe_queue_ready_i,
  output logic                                                 stall_o,
  output logic [7:0]                                           drop_cnt_o
);

  localparam int unsigned idx_width_lp = $clog2(els_p);
  localparam int unsigned q_width_lp   = 1 + vaddr_width_p + instr_width_p + meta_width_p;

  typedef enum logic {StRun, StStall} state_e;

  state_e                  state_q, state_d;
  logic [idx_width_lp:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]              drop_q, drop_d;
  logic [q_width_lp-1:0]   mem_q [els_p];

  logic                    empty, full, enq, deq;
  logic [idx_width_lp:0]   occ;
  logic [8:0]              drop_sum;
  logic [q_width_lp-1:0]   enq_entry;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[idx_width_lp-1:0] == rptr_q[idx_width_lp-1:0])
               & (wptr_q[idx_width_lp] != rptr_q[idx_width_lp]);
  assign occ   = wptr_q - rptr_q;

  assign fetch_ready_o = (state_q == StRun) & ~full & ~flush_i;
  assign enq           = fetch_v_i & fetch_ready_o;
  assign fe_queue_v_o  = ~empty & ~flush_i;
  assign deq           = fe_queue_v_o & fe_queue_ready_i;
  assign fe_queue_o    = empty ? '0 : mem_q[rptr_q[idx_width_lp-1:0]];
  assign stall_o       = (state_q == StStall);
  assign drop_cnt_o    = drop_q;

  assign enq_entry = fetch_exc_v_i
    ? {1'b1, fetch_pc_i, {(instr_width_p-2){1'b0}}, fetch_exc_i, {meta_width_p{1'b0}}}
    : {1'b0, fetch_pc_i, fetch_instr_i, fetch_meta_i};

  assign drop_sum = {1'b0, drop_q} + 9'(occ);

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    drop_d  = drop_q;
    if (flush_i) begin
      // Redirect discards all buffered work; the dropped entries are tallied.
      state_d = StRun;
      rptr_d  = wptr_q;
      drop_d  = drop_sum[8] ? 8'hff : drop_sum[7:0];
    end else begin
      if (enq) wptr_d = wptr_q + 1'b1;
      if (deq) rptr_d = rptr_q + 1'b1;
      unique case (state_q)
        StRun:   if (enq && fetch_exc_v_i) state_d = StStall;
        StStall: state_d = StStall;
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StRun;
      wptr_q  <= '0;
      rptr_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q[idx_width_lp-1:0]] <= enq_entry;
  end

endmodule

// File: tb/tb_bp_fe_queue_issuer.sv
// Bench for bp_fe_queue_issuer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bp_fe_queue_issuer;

  localparam int unsigned VA = 39, IW = 32, MW = 36, ELS = 2;
  localparam int unsigned QW = 1 + VA + IW + MW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic fetch_v = 1'b0, fetch_ready, fetch_exc_v = 1'b0, flush = 1'b0;
  logic [VA-1:0] fetch_pc = '0;
  logic [IW-1:0] fetch_instr = '0;
  logic [MW-1:0] fetch_meta = '0;
  logic [1:0] fetch_exc = '0;
  logic [QW-1:0] fe_queue;
  logic fe_queue_v, fe_queue_ready = 1'b0, stall;
  logic [7:0] drop_cnt;

  int checks = 0, failures = 0;
  bit check_en = 1'b0;

  // Reference model state
  logic [QW-1:0] mq[$];
  bit m_stall = 1'b0;
  int m_drop = 0;

  always #5 clk = ~clk;

  bp_fe_queue_issuer #(
    .vaddr_width_p(VA), .instr_width_p(IW), .meta_width_p(MW), .els_p(ELS)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .fetch_v_i(fetch_v), .fetch_ready_o(fetch_ready),
    .fetch_pc_i(fetch_pc), .fetch_instr_i(fetch_instr), .fetch_meta_i(fetch_meta),
    .fetch_exc_v_i(fetch_exc_v), .fetch_exc_i(fetch_exc), .flush_i(flush),
    .fe_queue_o(fe_queue), .fe_queue_v_o(fe_queue_v), .fe_queue_ready_i(fe_queue_ready),
    .stall_o(stall), .drop_cnt_o(drop_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [QW-1:0] make_msg(input bit ev, input logic [1:0] ec,
                                             input logic [VA-1:0] pc,
                                             input logic [IW-1:0] ins,
                                             input logic [MW-1:0] meta);
    logic [IW-1:0] code;
    code = '0;
    code[1:0] = ec;
    return ev ? {1'b1, pc, code, {MW{1'b0}}} : {1'b0, pc, ins, meta};
  endfunction

  // Compare DUT to the model mid-cycle, then advance the model across the next edge.
  always @(negedge clk) begin
    if (check_en) begin
      bit e_ready, e_v;
      logic [QW-1:0] e_data;
      e_ready = !m_stall && (mq.size() < ELS) && !flush;
      e_v     = (mq.size() > 0) && !flush;
      e_data  = (mq.size() > 0) ? mq[0] : '0;
      chk("fetch_ready", 128'(fetch_ready), 128'(e_ready));
      chk("fe_queue_v", 128'(fe_queue_v), 128'(e_v));
      chk("fe_queue", 128'(fe_queue), 128'(e_data));
      chk("stall", 128'(stall), 128'(m_stall));
      chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
      if (flush) begin
        m_drop = (m_drop + mq.size() > 255) ? 255 : m_drop + mq.size();
        mq.delete();
        m_stall = 1'b0;
      end else begin
        if (e_v && fe_queue_ready) void'(mq.pop_front());
        if (fetch_v && e_ready) begin
          mq.push_back(make_msg(fetch_exc_v, fetch_exc, fetch_pc, fetch_instr, fetch_meta));
          if (fetch_exc_v) m_stall = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed cycle: instr/meta are derived from the PC so literals are easy to write.
  task automatic cyc(input bit fv, input logic [VA-1:0] pc, input bit ev,
                     input logic [1:0] ec, input bit fl, input bit rdy);
    fetch_v = fv; fetch_pc = pc; fetch_exc_v = ev; fetch_exc = ec;
    fetch_instr = pc[31:0] ^ 32'ha5a5_0000;
    fetch_meta = MW'(pc) << 2;
    flush = fl; fe_queue_ready = rdy;
    step();
  endtask

  task automatic rand_cycles(input int n, input int flush_mod);
    for (int i = 0; i < n; i++) begin
      fetch_v = ($urandom_range(0, 3) != 0);
      fetch_pc = fetch_pc + 39'd4;
      fetch_instr = $urandom;
      fetch_meta = {4'($urandom), 32'($urandom)};
      fetch_exc_v = ($urandom_range(0, 15) == 0);
      fetch_exc = 2'($urandom_range(0, 2));
      flush = ($urandom_range(0, flush_mod - 1) == 0);
      fe_queue_ready = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  initial begin
    logic [QW-1:0] lit;
    #12;
    chk("reset_v", 128'(fe_queue_v), 128'(0));
    chk("reset_ready", 128'(fetch_ready), 128'(1));
    chk("reset_stall", 128'(stall), 128'(0));
    chk("reset_drop", 128'(drop_cnt), 128'(0));
    chk("reset_data", 128'(fe_queue), 128'(0));
    step();
    reset_n = 1'b1;
    check_en = 1'b1;

    // In-order fetch messages with ready held high
    cyc(1, 39'h1000, 0, 0, 0, 1);
    lit = {1'b0, 39'h1000, 32'ha5a5_1000, 36'h4000};
    chk("t1_first_msg", 128'(fe_queue), 128'(lit));
    cyc(1, 39'h1004, 0, 0, 0, 1);
    cyc(1, 39'h1008, 0, 0, 0, 1);
    cyc(0, 39'h0, 0, 0, 0, 1);
    cyc(0, 39'h0, 0, 0, 0, 1);

    // Backpressure: fills after two enqueues, head held until released
    cyc(1, 39'h3000, 0, 0, 0, 0);
    cyc(1, 39'h3004, 0, 0, 0, 0);
    chk("t2_full_ready", 128'(fetch_ready), 128'(0));
    cyc(1, 39'h3008, 0, 0, 0, 0);
    chk("t2_head_pc", 128'(fe_queue[QW-2 -: VA]), 128'(39'h3000));
    for (int i = 0; i < 3; i++) cyc(0, 39'h0, 0, 0, 0, 1);

    // Exception stalls fetch until a flush
    cyc(1, 39'h2000, 1, 2'd1, 0, 0);
    lit = {1'b1, 39'h2000, 32'h1, 36'h0};
    chk("t3_exc_msg", 128'(fe_queue), 128'(lit));
    chk("t3_stall", 128'(stall), 128'(1));
    chk("t3_ready", 128'(fetch_ready), 128'(0));
    cyc(1, 39'h2004, 0, 0, 0, 1);
    cyc(0, 39'h0, 0, 0, 1, 1);
    chk("t3_unstall", 128'(stall), 128'(0));

    // Flush of a full buffer counts both entries
    cyc(1, 39'h4000, 0, 0, 0, 0);
    cyc(1, 39'h4004, 0, 0, 0, 0);
    cyc(1, 39'h4008, 0, 0, 1, 1);
    fetch_v = 1'b0; flush = 1'b0;
    #1;
    chk("t4_v_after_flush", 128'(fe_queue_v), 128'(0));
    chk("t4_drop", 128'(drop_cnt), 128'(2));
    step();

    // Long random stream across many pointer wraps
    rand_cycles(400, 12);

    // Drive the drop counter into saturation
    for (int i = 0; i < 130; i++) begin
      cyc(1, 39'h5000, 0, 0, 0, 0);
      cyc(1, 39'h5004, 0, 0, 0, 0);
      cyc(0, 39'h0, 0, 0, 1, 0);
    end
    chk("sat_drop", 128'(drop_cnt), 128'(255));

    // Asynchronous reset mid-stream, checked before the next edge
    cyc(1, 39'h6000, 0, 0, 0, 0);
    cyc(1, 39'h6004, 1, 2'd2, 0, 0);
    check_en = 1'b0;
    fetch_v = 1'b0; flush = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_v", 128'(fe_queue_v), 128'(0));
    chk("t6_stall", 128'(stall), 128'(0));
    chk("t6_drop", 128'(drop_cnt), 128'(0));
    chk("t6_ready", 128'(fetch_ready), 128'(1));
    mq.delete();
    m_stall = 1'b0;
    m_drop = 0;
    step();
    reset_n = 1'b1;
    check_en = 1'b1;
    rand_cycles(60, 10);
    check_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
